// File: rtl/sm_adder_pkg.sv
// Shared widths, FSM state type and table-entry arithmetic for the sign-magnitude adder.
// Optional macro SM_ADD_CANON_ZERO_EN forces every zero-magnitude entry to a positive sign.
package sm_adder_pkg;

    localparam int unsigned MAG_W_DEF = 3;
    localparam int unsigned W_DEF     = MAG_W_DEF + 1;
    localparam int unsigned S_DEF     = MAG_W_DEF + 2;
    localparam int unsigned DEPTH_DEF = 1 << (2 * W_DEF);

    localparam int unsigned MAX_MAG_W = 4;
    localparam int unsigned MAX_W     = MAX_MAG_W + 1;
    localparam int unsigned MAX_S     = MAX_MAG_W + 2;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Operands arrive zero-extended to the widest legal format; the sign sits at bit mag_w.
    function automatic logic [MAX_S-1:0] sm_entry(
        input int unsigned      mag_w,
        input logic [MAX_W-1:0] a,
        input logic [MAX_W-1:0] b
    );
        logic [MAX_W-1:0] mask;
        logic [MAX_W-1:0] ma;
        logic [MAX_W-1:0] mb;
        logic [MAX_W-1:0] mag;
        logic             sa;
        logic             sb;
        logic             sign;
        mask = MAX_W'((1 << mag_w) - 1);
        ma   = a & mask;
        mb   = b & mask;
        sa   = a[mag_w];
        sb   = b[mag_w];
        if (sa == sb) begin
            mag  = ma + mb;
            sign = sa;
        end else if (ma > mb) begin
            mag  = ma - mb;
            sign = sa;
        end else if (mb > ma) begin
            mag  = mb - ma;
            sign = sb;
        end else begin
            mag  = '0;
            sign = sa;
        end
`ifdef SM_ADD_CANON_ZERO_EN
        if (mag == '0) begin
            sign = 1'b0;
        end
`endif
        return MAX_S'(mag) | (MAX_S'(sign) << (mag_w + 1));
    endfunction

endpackage

// File: rtl/sm_table_ram.sv
// Result table storage: one write port, registered read port, no reset on contents.
module sm_table_ram #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 5
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    // Read data only moves on an enabled read, so a stalled result stays put.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/table_sign_magnitude_adder.sv
// Table-driven sign-magnitude adder: builds a full sum table after reset, then serves lookups.
// Optional macro SM_ADD_CANON_ZERO_EN: every zero result gets sign 0 instead of a's sign.
module table_sign_magnitude_adder
    import sm_adder_pkg::*;
#(
    parameter int unsigned MAG_W = MAG_W_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [MAG_W:0]       a_i,
    input  logic [MAG_W:0]       b_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    output logic [MAG_W+1:0]     sum_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic                 init_done_o
);

    localparam int unsigned W  = MAG_W + 1;
    localparam int unsigned S  = MAG_W + 2;
    localparam int unsigned AW = 2 * W;

    state_e          state_q;
    state_e          state_d;
    logic [AW-1:0]   cnt_q;
    logic [AW-1:0]   rd_addr;
    logic [S-1:0]    wr_data;
    logic [S-1:0]    rd_data;
    logic            wr_en;
    logic            accept;
    logic            out_valid_q;
    logic            a_sign_q;
    logic [S-2:0]    mag_out;
    logic            sign_out;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            a_sign_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_INIT) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (accept) begin
                out_valid_q <= 1'b1;
                a_sign_q    <= a_i[W-1];
            end else if (out_ready_i) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        wr_en   = 1'b0;
        case (state_q)
            ST_INIT: begin
                wr_en = 1'b1;
                if (&cnt_q) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Entry at {x,y} is computed with x as operand a; the canonical address puts the smaller code first.
    assign wr_data = S'(sm_entry(MAG_W, MAX_W'(cnt_q[AW-1:W]), MAX_W'(cnt_q[W-1:0])));
    assign rd_addr = (a_i > b_i) ? {b_i, a_i} : {a_i, b_i};

    assign in_ready_o  = (state_q == ST_RUN) && (!out_valid_q || out_ready_i);
    assign accept      = in_valid_i && in_ready_o;
    assign init_done_o = (state_q == ST_RUN);
    assign out_valid_o = out_valid_q;

    sm_table_ram #(
        .AW (AW),
        .DW (S)
    ) u_table (
        .clk     (clk_i),
        .wr_en   (wr_en),
        .wr_addr (cnt_q),
        .wr_data (wr_data),
        .rd_en   (accept),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // A swapped lookup of +x/-x reads the entry built for the other order, so zero signs are re-derived here.
    assign mag_out = rd_data[S-2:0];
`ifdef SM_ADD_CANON_ZERO_EN
    assign sign_out = (mag_out == '0) ? 1'b0 : rd_data[S-1];
`else
    assign sign_out = (mag_out == '0) ? a_sign_q : rd_data[S-1];
`endif

    assign sum_o = out_valid_q ? {sign_out, mag_out} : '0;

endmodule

// File: tb/tb_table_sign_magnitude_adder.sv
// Self-checking bench for table_sign_magnitude_adder (MAG_W=3) against an integer-arithmetic model.
// Honours SM_ADD_CANON_ZERO_EN in the reference model.
module tb_table_sign_magnitude_adder;

    logic       clk_i;
    logic       rst_ni;
    logic [3:0] a_i;
    logic [3:0] b_i;
    logic       in_valid_i;
    logic       in_ready_o;
    logic [4:0] sum_o;
    logic       out_valid_o;
    logic       out_ready_i;
    logic       init_done_o;

    int checks = 0;
    int errors = 0;

    table_sign_magnitude_adder #(.MAG_W(3)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .a_i         (a_i),
        .b_i         (b_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .sum_o       (sum_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .init_done_o (init_done_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Signed integer sum of the two operands, re-encoded in sign-magnitude.
    function automatic logic [4:0] model(input logic [3:0] a, input logic [3:0] b);
        int va;
        int vb;
        int s;
        int mag;
        logic sign;
        va = a[3] ? -int'(a[2:0]) : int'(a[2:0]);
        vb = b[3] ? -int'(b[2:0]) : int'(b[2:0]);
        s  = va + vb;
        mag = (s < 0) ? -s : s;
        if (s < 0)      sign = 1'b1;
        else if (s > 0) sign = 1'b0;
        else begin
`ifdef SM_ADD_CANON_ZERO_EN
            sign = 1'b0;
`else
            sign = a[3];
`endif
        end
        return {sign, 4'(mag)};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_init(input string tag);
        int n;
        n = 0;
        check_output({tag, "_ready_low"}, 32'(in_ready_o), 32'd0);
        check_output({tag, "_done_low"}, 32'(init_done_o), 32'd0);
        while (!in_ready_o && n < 1000) begin
            tick();
            if (!in_ready_o) begin
                if (init_done_o !== 1'b0) begin
                    check_output({tag, "_done_early"}, 32'(init_done_o), 32'd0);
                end
            end
            n++;
        end
        check_output({tag, "_cycles"}, 32'(n), 32'd256);
        check_output({tag, "_done_high"}, 32'(init_done_o), 32'd1);
    endtask

    task automatic apply_stimulus(input logic [3:0] a, input logic [3:0] b, input string tag);
        a_i = a;
        b_i = b;
        in_valid_i  = 1'b1;
        out_ready_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        check_output({tag, "_valid"}, 32'(out_valid_o), 32'd1);
        check_output({tag, "_sum"}, 32'(sum_o), 32'(model(a, b)));
    endtask

    initial begin
        logic [4:0] exp_q[$];
        logic [4:0] exp1;
        logic [4:0] exp2;
        logic [3:0] ra;
        logic [3:0] rb;

        rst_ni = 1'b0;
        a_i = '0;
        b_i = '0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        tick();
        tick();
        check_output("rst_out_valid", 32'(out_valid_o), 32'd0);
        check_output("rst_in_ready", 32'(in_ready_o), 32'd0);
        check_output("rst_init_done", 32'(init_done_o), 32'd0);
        check_output("rst_sum", 32'(sum_o), 32'd0);

        rst_ni = 1'b1;
        wait_init("init1");

        apply_stimulus(4'b0011, 4'b1101, "p3_m5");
        check_output("p3_m5_const", 32'(sum_o), 32'b10010);
        apply_stimulus(4'b1101, 4'b0011, "m5_p3");
        check_output("m5_p3_const", 32'(sum_o), 32'b10010);
        apply_stimulus(4'b0111, 4'b0111, "p7_p7");
        check_output("p7_p7_const", 32'(sum_o), 32'b01110);
        apply_stimulus(4'b1111, 4'b1111, "m7_m7");
        check_output("m7_m7_const", 32'(sum_o), 32'b11110);
        apply_stimulus(4'b0100, 4'b1100, "p4_m4");
        check_output("p4_m4_const", 32'(sum_o), 32'b00000);
        apply_stimulus(4'b1100, 4'b0100, "m4_p4");
`ifdef SM_ADD_CANON_ZERO_EN
        check_output("m4_p4_const", 32'(sum_o), 32'b00000);
`else
        check_output("m4_p4_const", 32'(sum_o), 32'b10000);
`endif
        apply_stimulus(4'b1000, 4'b1000, "m0_m0");
        tick();
        check_output("valid_clears", 32'(out_valid_o), 32'd0);

        // Back-to-back random pairs with the consumer always ready.
        out_ready_i = 1'b1;
        for (int i = 0; i < 24; i++) begin
            ra = 4'($urandom);
            rb = 4'($urandom);
            a_i = ra;
            b_i = rb;
            in_valid_i = 1'b1;
            exp_q.push_back(model(ra, rb));
            tick();
            check_output("b2b_valid", 32'(out_valid_o), 32'd1);
            check_output("b2b_sum", 32'(sum_o), 32'(exp_q.pop_front()));
        end
        in_valid_i = 1'b0;
        tick();
        check_output("b2b_drain", 32'(out_valid_o), 32'd0);

        // Consumer stalls for three cycles while a second pair waits.
        ra = 4'($urandom);
        rb = 4'($urandom);
        exp1 = model(ra, rb);
        a_i = ra;
        b_i = rb;
        in_valid_i  = 1'b1;
        out_ready_i = 1'b0;
        tick();
        ra = 4'($urandom);
        rb = 4'($urandom);
        exp2 = model(ra, rb);
        a_i = ra;
        b_i = rb;
        #1;
        for (int i = 0; i < 3; i++) begin
            check_output("stall_ready", 32'(in_ready_o), 32'd0);
            check_output("stall_valid", 32'(out_valid_o), 32'd1);
            check_output("stall_sum", 32'(sum_o), 32'(exp1));
            tick();
        end
        out_ready_i = 1'b1;
        #1;
        check_output("stall_release_ready", 32'(in_ready_o), 32'd1);
        tick();
        in_valid_i = 1'b0;
        check_output("stall_next_valid", 32'(out_valid_o), 32'd1);
        check_output("stall_next_sum", 32'(sum_o), 32'(exp2));
        tick();
        check_output("stall_no_dup", 32'(out_valid_o), 32'd0);

        // Reset while a result is pending, then rebuild and sweep every pair.
        a_i = 4'b0101;
        b_i = 4'b0010;
        in_valid_i  = 1'b1;
        out_ready_i = 1'b0;
        tick();
        in_valid_i = 1'b0;
        check_output("pre_rst_valid", 32'(out_valid_o), 32'd1);
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        check_output("mid_rst_valid", 32'(out_valid_o), 32'd0);
        check_output("mid_rst_sum", 32'(sum_o), 32'd0);
        out_ready_i = 1'b1;
        wait_init("init2");

        for (int i = 0; i < 256; i++) begin
            ra = 4'(i >> 4);
            rb = 4'(i);
            a_i = ra;
            b_i = rb;
            in_valid_i = 1'b1;
            exp1 = model(ra, rb);
            tick();
            check_output($sformatf("sweep_%0h_%0h", ra, rb), 32'(sum_o), 32'(exp1));
        end
        in_valid_i = 1'b0;
        tick();
        check_output("sweep_drain", 32'(out_valid_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
